// File: rtl/cache_refill_ctrl.sv
// Miss handler on the memory side of the cache: optional victim write-back,
// then a word-by-word block fetch, ending in a single-cycle block-fill command.

module cache_refill_word #(
  parameter int WW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [WW-1:0] d_i,
  output logic [WW-1:0] q_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   q_o <= '0;
    else if (we_i) q_o <= d_i;
  end
endmodule

module cache_refill_ctrl #(
  parameter int Addr_Width             = 32,
  parameter int Word_Size_Bytes        = 4,
  parameter int Cache_Block_Size_Words = 8,
  parameter int Command_Width          = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         miss_valid_i,
  output logic                                         miss_ready_o,
  input  logic [Addr_Width-1:0]                        miss_addr_i,
  input  logic                                         evict_i,
  input  logic [Addr_Width-1:0]                        evict_addr_i,
  input  logic [Word_Size_Bytes*8*Cache_Block_Size_Words-1:0] evict_data_i,
  output logic                                         mem_req_o,
  output logic                                         mem_we_o,
  output logic [Addr_Width-1:0]                        mem_addr_o,
  output logic [Word_Size_Bytes*8-1:0]                 mem_wdata_o,
  input  logic                                         mem_gnt_i,
  input  logic                                         mem_rvalid_i,
  input  logic [Word_Size_Bytes*8-1:0]                 mem_rdata_i,
  output logic [Command_Width-1:0]                     fill_command_o,
  output logic [Addr_Width-1:0]                        fill_addr_o,
  output logic [Word_Size_Bytes*8*Cache_Block_Size_Words-1:0] fill_data_o,
  output logic                                         busy_o
);
  localparam int WW    = Word_Size_Bytes * 8;
  localparam int NW    = Cache_Block_Size_Words;
  localparam int OFF   = $clog2(Word_Size_Bytes * Cache_Block_Size_Words);
  localparam int WOFF  = $clog2(Word_Size_Bytes);
  localparam int KW    = $clog2(Cache_Block_Size_Words);

  localparam logic [KW-1:0]            K_LAST   = KW'(NW - 1);
  localparam logic [Addr_Width-1:0]    OFF_MASK = Addr_Width'((64'd1 << OFF) - 64'd1);
  localparam logic [Command_Width-1:0] CMD_NONE = '0;
  localparam logic [Command_Width-1:0] CMD_FILL = Command_Width'(1);

  typedef enum logic [2:0] {IDLE, WB, RD_REQ, RD_WAIT, FILL} state_t;

  state_t                   state;
  logic [KW-1:0]            k, k_nxt;
  logic [Addr_Width-1:0]    miss_base, evict_base;
  logic [NW-1:0][WW-1:0]    evict_blk;
  logic [NW-1:0][WW-1:0]    rd_buf, rd_block;
  logic [NW-1:0]            buf_we;

  function automatic logic [Addr_Width-1:0] block_base(input logic [Addr_Width-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  function automatic logic [Addr_Width-1:0] word_addr(input logic [Addr_Width-1:0] base,
                                                      input logic [KW-1:0] idx);
    return base | (Addr_Width'(idx) << WOFF);
  endfunction

  assign k_nxt        = k + KW'(1);
  assign miss_ready_o = (state == IDLE);
  assign busy_o       = (state != IDLE);

  // Read buffer: one slot per block word, written only by rvalid in RD_WAIT.
  for (genvar i = 0; i < NW; i++) begin : g_word
    assign buf_we[i] = (state == RD_WAIT) && mem_rvalid_i && (k == KW'(i));
    cache_refill_word #(.WW(WW)) u_word (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (buf_we[i]),
      .d_i    (mem_rdata_i),
      .q_o    (rd_buf[i])
    );
  end

  // The last word lands in the same edge that launches FILL, so merge it in here.
  always_comb begin
    rd_block    = rd_buf;
    rd_block[k] = mem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      k              <= '0;
      miss_base      <= '0;
      evict_base     <= '0;
      evict_blk      <= '0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      fill_command_o <= CMD_NONE;
      fill_addr_o    <= '0;
      fill_data_o    <= '0;
    end else begin
      unique case (state)
        IDLE: if (miss_valid_i && miss_ready_o) begin
          miss_base  <= block_base(miss_addr_i);
          evict_base <= block_base(evict_addr_i);
          evict_blk  <= evict_data_i;
          k          <= '0;
          mem_req_o  <= 1'b1;
          if (evict_i) begin
            state       <= WB;
            mem_we_o    <= 1'b1;
            mem_addr_o  <= block_base(evict_addr_i);
            mem_wdata_o <= evict_data_i[WW-1:0];
          end else begin
            state       <= RD_REQ;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= block_base(miss_addr_i);
            mem_wdata_o <= '0;
          end
        end
        WB: if (mem_gnt_i) begin
          if (k == K_LAST) begin
            k           <= '0;
            state       <= RD_REQ;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= miss_base;
            mem_wdata_o <= '0;
          end else begin
            k           <= k_nxt;
            mem_addr_o  <= word_addr(evict_base, k_nxt);
            mem_wdata_o <= evict_blk[k_nxt];
          end
        end
        RD_REQ: if (mem_gnt_i) begin
          state     <= RD_WAIT;
          mem_req_o <= 1'b0;
        end
        RD_WAIT: if (mem_rvalid_i) begin
          if (k == K_LAST) begin
            state          <= FILL;
            k              <= '0;
            fill_command_o <= CMD_FILL;
            fill_addr_o    <= miss_base;
            fill_data_o    <= rd_block;
          end else begin
            k          <= k_nxt;
            state      <= RD_REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= word_addr(miss_base, k_nxt);
          end
        end
        FILL: begin
          state          <= IDLE;
          fill_command_o <= CMD_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
